// File: rtl/module_multiword_adder_ctrl.sv
// Word-serial wide add/subtract controller built around one ripple carry adder.
// Processes one RCAWIDE-bit word per cycle, LSW first, with a registered inter-word carry.

module module_ripple_carry_adder #(
   parameter int RCAWIDE = 16
) (
   input  logic [RCAWIDE-1:0] a_i,
   input  logic [RCAWIDE-1:0] b_i,
   input  logic               carry_i,
   output logic [RCAWIDE-1:0] sum_o,
   output logic               carry_o
);

   always_comb begin
      logic c;
      c = carry_i;
      sum_o = '0;
      for (int i = 0; i < RCAWIDE; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ c;
         c = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      carry_o = c;
   end

endmodule

module module_multiword_adder_ctrl #(
   parameter int RCAWIDE = 16,
   parameter int WORDS   = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic                     sub_i,
   input  logic [RCAWIDE*WORDS-1:0] a_i,
   input  logic [RCAWIDE*WORDS-1:0] b_i,
   input  logic                     carry_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [RCAWIDE*WORDS-1:0] sum_o,
   output logic                     carry_o,
   output logic                     overflow_o
);

   localparam int W  = RCAWIDE * WORDS;
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [WORDS-1:0][RCAWIDE-1:0] a_q, b_q, sum_q;
   logic [CW-1:0]                 cnt_q;
   logic                          cy_q;
   logic                          carry_q;
   logic                          ovf_q;
   logic                          last;
   logic [RCAWIDE-1:0]            rca_sum;
   logic                          rca_co;

   assign last = (cnt_q == CW'(WORDS - 1));

   module_ripple_carry_adder #(
      .RCAWIDE(RCAWIDE)
   ) u_rca (
      .a_i    (a_q[cnt_q]),
      .b_i    (b_q[cnt_q]),
      .carry_i(cy_q),
      .sum_o  (rca_sum),
      .carry_o(rca_co)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (valid_i) state_d = RUN;
         RUN:     if (last)    state_d = DONE;
         DONE:    if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // b is stored pre-inverted for subtract so RUN never needs to know the op
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (valid_i) begin
                  a_q   <= a_i;
                  b_q   <= sub_i ? ~b_i : b_i;
                  cy_q  <= sub_i | carry_i;
                  cnt_q <= '0;
               end
            end
            RUN: begin
               sum_q[cnt_q] <= rca_sum;
               cy_q         <= rca_co;
               if (last) begin
                  carry_q <= rca_co;
                  ovf_q   <= (a_q[WORDS-1][RCAWIDE-1] == b_q[WORDS-1][RCAWIDE-1])
                          && (rca_sum[RCAWIDE-1] != a_q[WORDS-1][RCAWIDE-1]);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_o    = (state_q == IDLE);
   assign valid_o    = (state_q == DONE);
   assign sum_o      = W'(sum_q);
   assign carry_o    = carry_q;
   assign overflow_o = ovf_q;

endmodule
